// File: rtl/aes_pkg.sv
// aes_pkg: DMA FSM state encoding and AHB-Lite transfer constants shared by aes_dma_ctrl
package aes_pkg;
  typedef enum logic [2:0] {IDLE, RD, SEND, WAIT, WR, DONE, ERR} state_t;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HBURST_INCR4 = 3'b011;
endpackage

// File: rtl/aes_dma_ctrl.sv
// aes_dma_ctrl: AHB-Lite DMA reading 16-byte blocks into the cipher core and writing results back (hclk/hresetn, start/src/dst/num_bytes config, busy/done/error status, m_h* master, pt_*/ct_* core streams)
module aes_dma_ctrl
  import aes_pkg::*;
#(
  parameter int LEN_W = 24
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          start,
  input  logic [31:0]   src_addr,
  input  logic [31:0]   dst_addr,
  input  logic [31:0]   num_bytes,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [31:0]   m_haddr,
  output logic [1:0]    m_htrans,
  output logic          m_hwrite,
  output logic [2:0]    m_hsize,
  output logic [2:0]    m_hburst,
  output logic [31:0]   m_hwdata,
  input  logic [31:0]   m_hrdata,
  input  logic          m_hready,
  input  logic          m_hresp,
  output logic [127:0]  pt_data,
  output logic          pt_valid,
  input  logic          pt_ready,
  input  logic [127:0]  ct_data,
  input  logic          ct_valid,
  output logic          ct_ready
);
  state_t state, nxt;
  logic [31:0] src, dst;
  logic [LEN_W-1:0] cnt, len_blk;
  logic [127:0] blk;
  logic [2:0] abeat;
  logic [1:0] dbeat;
  logic dph, bus, aph, last, berr, unused;
  assign len_blk = num_bytes[LEN_W+3:4];
  assign unused = ^{num_bytes, src_addr[3:0], dst_addr[3:0]};
  assign bus = state == RD || state == WR;
  assign aph = bus && !abeat[2];
  assign berr = bus && dph && m_hresp;
  assign last = bus && dph && m_hready && !m_hresp && dbeat == 2'd3;
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !start ? IDLE : len_blk == '0 ? DONE : RD;
      RD: nxt = berr ? ERR : last ? SEND : RD;
      SEND: nxt = pt_ready ? WAIT : SEND;
      WAIT: nxt = ct_valid ? WR : WAIT;
      WR: nxt = berr ? ERR : !last ? WR : cnt == LEN_W'(1) ? DONE : RD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      src <= '0;
      dst <= '0;
      cnt <= '0;
      blk <= '0;
      abeat <= '0;
      dbeat <= '0;
      dph <= 1'b0;
      error <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        src <= {src_addr[31:4], 4'b0};
        dst <= {dst_addr[31:4], 4'b0};
        cnt <= len_blk;
        error <= 1'b0;
      end
      if (berr) error <= 1'b1;
      if (bus && m_hready && !berr) begin
        if (aph) abeat <= abeat + 3'd1;
        dph <= aph;
        if (dph) dbeat <= dbeat + 2'd1;
        if (dph && state == RD) blk[{~dbeat, 5'b0} +: 32] <= m_hrdata;
      end
      if (nxt != state) begin
        abeat <= '0;
        dbeat <= '0;
        dph <= 1'b0;
      end
      if (state == WAIT && ct_valid) blk <= ct_data;
      if (state == WR && last) begin
        src <= src + 32'd16;
        dst <= dst + 32'd16;
        cnt <= cnt - LEN_W'(1);
      end
    end
  assign m_htrans = !aph ? HTRANS_IDLE : abeat == 3'd0 ? HTRANS_NONSEQ : HTRANS_SEQ;
  assign m_haddr = aph ? (state == WR ? dst : src) + {27'b0, abeat, 2'b00} : 32'b0;
  assign m_hwrite = aph && state == WR;
  assign m_hsize = aph ? HSIZE_WORD : 3'b0;
  assign m_hburst = aph ? HBURST_INCR4 : 3'b0;
  assign m_hwdata = state == WR && dph ? blk[{~dbeat, 5'b0} +: 32] : 32'b0;
  assign pt_data = blk;
  assign pt_valid = state == SEND;
  assign ct_ready = state == WAIT;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_aes_dma_ctrl.sv
// tb_aes_dma_ctrl: scoreboard bench for aes_dma_ctrl with AHB memory and xor-key cipher core models
module tb_aes_dma_ctrl;
  logic hclk = 1'b0, hresetn = 1'b1, start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0, num_bytes = '0;
  logic busy, done, error;
  logic [31:0] m_haddr, m_hwdata, m_hrdata;
  logic [1:0] m_htrans;
  logic m_hwrite, m_hresp;
  logic m_hready = 1'b1;
  logic [2:0] m_hsize, m_hburst;
  logic [127:0] pt_data, ct_data, ct_q;
  logic pt_valid, pt_ready, ct_valid, ct_ready, ct_pend;
  int checks = 0, errors = 0, done_seen = 0, done_exp = 0;
  logic [34:0] exp_bus[$];
  logic [31:0] exp_wd[$];
  logic [127:0] exp_pt[$];
  logic stall_en = 1'b0, err_en = 1'b0, pt_rdy_en = 1'b1;
  logic [31:0] err_addr = '0, kw = '0;
  logic dp_valid, dp_write;
  logic [31:0] dp_addr;
  logic stl_prev = 1'b0;
  logic [33:0] stl_val = '0;

  aes_dma_ctrl #(.LEN_W(24)) dut (
    .hclk(hclk), .hresetn(hresetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_bytes(num_bytes), .busy(busy), .done(done), .error(error), .m_haddr(m_haddr),
    .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
    .m_hwdata(m_hwdata), .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready), .ct_data(ct_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready)
  );

  initial forever #5 hclk = ~hclk;

  initial forever begin
    @(posedge hclk);
    #1 m_hready = !stall_en || ($urandom_range(0, 2) != 0);
  end

  always @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr <= '0;
    end else if (m_hready) begin
      dp_valid <= m_htrans != 2'b00;
      dp_write <= m_hwrite;
      dp_addr <= m_haddr;
    end
  assign m_hrdata = dp_valid && !dp_write ? {16'hCAFE, dp_addr[15:0]} : 32'h0;
  assign m_hresp = dp_valid && err_en && dp_addr == err_addr;

  always @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      ct_pend <= 1'b0;
      ct_q <= '0;
    end else if (pt_valid && pt_ready) begin
      ct_pend <= 1'b1;
      ct_q <= pt_data ^ {4{kw}};
    end else if (ct_valid && ct_ready) ct_pend <= 1'b0;
  assign ct_valid = ct_pend;
  assign ct_data = ct_q;
  assign pt_ready = pt_rdy_en;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", n, act, req);
    end
  endtask

  always @(negedge hclk) begin
    if (!hresetn) stl_prev = 1'b0;
    else begin
      if (stl_prev) chk("stall_hold", 128'({m_htrans, m_haddr}), 128'(stl_val));
      stl_prev = m_htrans != 2'b00 && !m_hready;
      stl_val = {m_htrans, m_haddr};
      if (m_hready && m_htrans != 2'b00) begin
        chk("hsize_hburst", 128'({m_hsize, m_hburst}), 128'({3'b010, 3'b011}));
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected act=%h req=none", {m_hwrite, m_htrans, m_haddr});
        end else chk("bus_beat", 128'({m_hwrite, m_htrans, m_haddr}), 128'(exp_bus.pop_front()));
      end
      if (dp_valid && dp_write && m_hready) begin
        if (exp_wd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wdata_unexpected act=%h req=none", m_hwdata);
        end else chk("wdata", 128'(m_hwdata), 128'(exp_wd.pop_front()));
      end
      if (pt_valid && pt_ready) begin
        if (exp_pt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pt_unexpected act=%h req=none", pt_data);
        end else chk("pt_data", pt_data, exp_pt.pop_front());
      end
      if (done) done_seen++;
    end
  end

  function automatic logic [31:0] w(input logic [31:0] a);
    return {16'hCAFE, a[15:0]};
  endfunction

  task automatic push_rd(input logic [31:0] s, input int n);
    for (int k = 0; k < n; k++) exp_bus.push_back({1'b0, k == 0 ? 2'b10 : 2'b11, s + 32'(4 * k)});
  endtask

  task automatic push_wr(input logic [31:0] s, input logic [31:0] d, input int na, input int nd);
    for (int k = 0; k < na; k++) exp_bus.push_back({1'b1, k == 0 ? 2'b10 : 2'b11, d + 32'(4 * k)});
    for (int k = 0; k < nd; k++) exp_wd.push_back(w(s + 32'(4 * k)) ^ kw);
  endtask

  task automatic push_blk(input logic [31:0] s, input logic [31:0] d);
    push_rd(s, 4);
    exp_pt.push_back({w(s), w(s + 32'd4), w(s + 32'd8), w(s + 32'd12)});
    push_wr(s, d, 4, 4);
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    src_addr = s;
    dst_addr = d;
    num_bytes = n;
    start = 1'b1;
    @(posedge hclk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(posedge hclk);
      #1 t++;
    end
    chk("idle_in_budget", 128'(busy), 128'(0));
  endtask

  task automatic settle(input string n);
    chk({n, "_bus_left"}, 128'(exp_bus.size()), 128'(0));
    chk({n, "_wd_left"}, 128'(exp_wd.size()), 128'(0));
    chk({n, "_pt_left"}, 128'(exp_pt.size()), 128'(0));
    chk({n, "_done_count"}, 128'(done_seen), 128'(done_exp));
  endtask

  initial begin
    logic hit;
    #1 hresetn = 1'b0;
    #1;
    chk("rst_htrans", 128'(m_htrans), 128'(0));
    chk("rst_haddr", 128'(m_haddr), 128'(0));
    chk("rst_hwrite_size_burst", 128'({m_hwrite, m_hsize, m_hburst}), 128'(0));
    chk("rst_hwdata", 128'(m_hwdata), 128'(0));
    chk("rst_status", 128'({busy, done, error}), 128'(0));
    chk("rst_pt_valid", 128'(pt_valid), 128'(0));
    chk("rst_ct_ready", 128'(ct_ready), 128'(0));
    chk("rst_pt_data", pt_data, 128'(0));
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(posedge hclk);
    #1;

    kw = 32'h0;
    exp_bus.push_back({1'b0, 2'b10, 32'h0000_0100});
    exp_bus.push_back({1'b0, 2'b11, 32'h0000_0104});
    exp_bus.push_back({1'b0, 2'b11, 32'h0000_0108});
    exp_bus.push_back({1'b0, 2'b11, 32'h0000_010C});
    exp_pt.push_back(128'hCAFE0100_CAFE0104_CAFE0108_CAFE010C);
    exp_bus.push_back({1'b1, 2'b10, 32'h0000_0200});
    exp_bus.push_back({1'b1, 2'b11, 32'h0000_0204});
    exp_bus.push_back({1'b1, 2'b11, 32'h0000_0208});
    exp_bus.push_back({1'b1, 2'b11, 32'h0000_020C});
    exp_wd.push_back(32'hCAFE0100);
    exp_wd.push_back(32'hCAFE0104);
    exp_wd.push_back(32'hCAFE0108);
    exp_wd.push_back(32'hCAFE010C);
    done_exp++;
    pulse_start(32'h100, 32'h200, 32'd16);
    chk("t1_busy", 128'(busy), 128'(1));
    wait_idle(200);
    settle("t1");

    kw = 32'hFFFF_0000;
    stall_en = 1'b1;
    for (int b = 0; b < 3; b++) push_blk(32'h1000 + 32'(16 * b), 32'h2000 + 32'(16 * b));
    done_exp++;
    pulse_start(32'h1000, 32'h2000, 32'd48);
    wait_idle(3000);
    stall_en = 1'b0;
    repeat (2) @(posedge hclk);
    #1 settle("t2");

    kw = 32'h0;
    err_en = 1'b1;
    err_addr = 32'h3014;
    push_blk(32'h3000, 32'h4000);
    push_rd(32'h3010, 3);
    pulse_start(32'h3000, 32'h4000, 32'd48);
    wait_idle(500);
    chk("t4_error", 128'(error), 128'(1));
    err_en = 1'b0;
    repeat (5) @(posedge hclk);
    #1 settle("t4");

    for (int i = 0; i < 2; i++) begin
      pulse_start(32'h5550, 32'h6660, i == 0 ? 32'd0 : 32'd15);
      done_exp++;
      chk("t3_error_cleared", 128'(error), 128'(0));
      chk("t3_done_high", 128'({done, busy}), 128'(2'b11));
      @(posedge hclk);
      #1 chk("t3_done_low", 128'({done, busy}), 128'(0));
    end
    settle("t3");

    pt_rdy_en = 1'b0;
    push_blk(32'h7000, 32'h8000);
    done_exp++;
    pulse_start(32'h7000, 32'h8000, 32'd16);
    for (int t = 0; t < 100 && !pt_valid; t++) begin
      @(posedge hclk);
      #1;
    end
    chk("t6_pt_valid", 128'(pt_valid), 128'(1));
    pulse_start(32'h9000, 32'hA000, 32'd32);
    for (int t = 0; t < 10; t++) begin
      chk("t6_pt_hold", pt_data, 128'hCAFE7000_CAFE7004_CAFE7008_CAFE700C);
      chk("t6_pt_valid_hold", 128'(pt_valid), 128'(1));
      @(posedge hclk);
      #1;
    end
    pt_rdy_en = 1'b1;
    wait_idle(300);
    repeat (5) @(posedge hclk);
    #1 settle("t6");

    push_rd(32'h5000, 4);
    exp_pt.push_back(128'hCAFE5000_CAFE5004_CAFE5008_CAFE500C);
    push_wr(32'h5000, 32'h6000, 2, 1);
    pulse_start(32'h5000, 32'h6000, 32'd16);
    hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(posedge hclk);
      #1 hit = m_htrans != 2'b00 && m_hwrite && m_haddr == 32'h6008;
    end
    chk("t5_reached_wr_beat2", 128'(hit), 128'(1));
    #2 hresetn = 1'b0;
    #1;
    chk("t5_async_htrans", 128'(m_htrans), 128'(0));
    chk("t5_async_busy", 128'(busy), 128'(0));
    chk("t5_async_hwrite", 128'(m_hwrite), 128'(0));
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    repeat (20) @(posedge hclk);
    #1 chk("t5_idle_after", 128'({busy, done}), 128'(0));
    settle("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end
endmodule
